// File: rtl/pwm_deadtime.sv
// Complementary dead-time gate stage.
// Splits one PWM stream into hi/lo drives that never overlap.
module pwm_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dead_cycles,
  input  logic            fault,
  input  logic            fault_clr,
  output logic            out_hi,
  output logic            out_lo,
  output logic            fault_latched
);

  typedef enum logic [2:0] {
    S_OFF,
    S_DTH,
    S_HIGH,
    S_DTL,
    S_LOW,
    S_FLT
  } state_t;

  state_t          state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            pwm_q;
  logic            cnt_done;
  logic            dead_d;
  logic            enter_dead;

  assign cnt_done = (cnt_q <= DT_W'(1));
  assign dead_d   = (state_d == S_DTH) || (state_d == S_DTL);
  assign enter_dead = dead_d && (state_d != state_q);

  // Next-state decode: fault beats disable beats normal flow.
  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = S_FLT;
    end else if (state_q == S_FLT) begin
      if (fault_clr) state_d = S_OFF;
    end else if (!en) begin
      state_d = S_OFF;
    end else begin
      unique case (state_q)
        S_OFF:  state_d = pwm_q ? S_DTH : S_DTL;
        S_DTH: begin
          if (!pwm_q)        state_d = S_LOW;
          else if (cnt_done) state_d = S_HIGH;
        end
        S_HIGH: if (!pwm_q) state_d = S_DTL;
        S_DTL: begin
          if (pwm_q)         state_d = S_HIGH;
          else if (cnt_done) state_d = S_LOW;
        end
        S_LOW:  if (pwm_q) state_d = S_DTH;
        default: state_d = S_OFF;
      endcase
    end
  end

  // Dead counter: reload on entry, count down while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (enter_dead) begin
      cnt_d = dead_cycles;
    end else if (dead_d) begin
      cnt_d = cnt_q - DT_W'(1);
    end
  end

  // State, counter, input sync and registered gate outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= S_OFF;
      cnt_q         <= '0;
      pwm_q         <= 1'b0;
      out_hi        <= 1'b0;
      out_lo        <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pwm_q         <= pwm_in;
      out_hi        <= (state_d == S_HIGH);
      out_lo        <= (state_d == S_LOW);
      fault_latched <= (state_d == S_FLT);
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: vector table with scoreboard,
// plus timed sequences for dead-interval corner cases.
module tb_pwm_deadtime;

  logic       clk;
  logic       n_reset;
  logic       en;
  logic       pwm_in;
  logic [7:0] dead_cycles;
  logic       fault;
  logic       fault_clr;
  logic       out_hi;
  logic       out_lo;
  logic       fault_latched;

  int checks = 0;
  int errors = 0;

  pwm_deadtime #(.DT_W(8)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .en           (en),
    .pwm_in       (pwm_in),
    .dead_cycles  (dead_cycles),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .out_hi       (out_hi),
    .out_lo       (out_lo),
    .fault_latched(fault_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       pwm;
    logic [7:0] d;
    logic       f;
    logic       fc;
    logic [2:0] exp;
  } vec_t;

  vec_t       tbl[34];
  logic [2:0] sb_q[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic p,
                              input int d, input logic f,
                              input logic fc, input logic [2:0] x);
    vec_t v;
    v.en = e; v.pwm = p; v.d = 8'(d);
    v.f = f; v.fc = fc; v.exp = x;
    return v;
  endfunction

  // Overlap watchdog on every falling edge.
  always @(negedge clk) begin
    checks++;
    if (out_hi && out_lo) begin
      errors++;
      $display("FAIL overlap: hi=%0b lo=%0b at %0t",
               out_hi, out_lo, $time);
    end
  end

  initial begin
    int n;
    int hi_n;
    int lo_n;
    int z_n;
    logic [2:0] got;
    logic [2:0] e;

    // expected {hi,lo,flt} after each edge
    tbl[0]  = mk(1, 0, 2, 0, 0, 3'b000);
    tbl[1]  = mk(1, 0, 2, 0, 0, 3'b000);
    tbl[2]  = mk(1, 0, 2, 0, 0, 3'b010);
    tbl[3]  = mk(1, 0, 2, 0, 0, 3'b010);
    tbl[4]  = mk(1, 1, 2, 0, 0, 3'b010);
    tbl[5]  = mk(1, 1, 2, 0, 0, 3'b000);
    tbl[6]  = mk(1, 1, 2, 0, 0, 3'b000);
    tbl[7]  = mk(1, 1, 2, 0, 0, 3'b100);
    tbl[8]  = mk(1, 1, 2, 0, 0, 3'b100);
    tbl[9]  = mk(1, 0, 4, 0, 0, 3'b100);
    tbl[10] = mk(1, 1, 4, 0, 0, 3'b000);
    tbl[11] = mk(1, 1, 4, 0, 0, 3'b100);
    tbl[12] = mk(1, 0, 4, 0, 0, 3'b100);
    tbl[13] = mk(1, 0, 4, 0, 0, 3'b000);
    tbl[14] = mk(1, 0, 4, 0, 0, 3'b000);
    tbl[15] = mk(1, 0, 4, 0, 0, 3'b000);
    tbl[16] = mk(1, 0, 4, 0, 0, 3'b000);
    tbl[17] = mk(1, 0, 4, 0, 0, 3'b010);
    tbl[18] = mk(1, 1, 4, 0, 0, 3'b010);
    tbl[19] = mk(1, 0, 4, 0, 0, 3'b000);
    tbl[20] = mk(1, 0, 4, 0, 0, 3'b010);
    tbl[21] = mk(1, 0, 4, 0, 0, 3'b010);
    tbl[22] = mk(0, 0, 4, 0, 0, 3'b000);
    tbl[23] = mk(1, 0, 0, 0, 0, 3'b000);
    tbl[24] = mk(1, 0, 0, 0, 0, 3'b010);
    tbl[25] = mk(1, 1, 1, 0, 0, 3'b010);
    tbl[26] = mk(1, 1, 1, 0, 0, 3'b000);
    tbl[27] = mk(1, 1, 1, 0, 0, 3'b100);
    tbl[28] = mk(1, 1, 1, 1, 0, 3'b001);
    tbl[29] = mk(1, 1, 1, 1, 1, 3'b001);
    tbl[30] = mk(1, 1, 1, 0, 0, 3'b001);
    tbl[31] = mk(1, 0, 1, 0, 1, 3'b000);
    tbl[32] = mk(1, 0, 1, 0, 0, 3'b000);
    tbl[33] = mk(1, 0, 1, 0, 0, 3'b010);

    n_reset = 1'b0;
    en = 1'b0; pwm_in = 1'b0; dead_cycles = 8'd0;
    fault = 1'b0; fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", int'(out_hi), 0);
    chk("rst_lo", int'(out_lo), 0);
    chk("rst_flt", int'(fault_latched), 0);
    @(negedge clk);
    n_reset = 1'b1;

    // table: drive, push expectation, pop after the edge
    for (int i = 0; i < 34; i++) begin
      if (i != 0) @(negedge clk);
      en = tbl[i].en; pwm_in = tbl[i].pwm;
      dead_cycles = tbl[i].d;
      fault = tbl[i].f; fault_clr = tbl[i].fc;
      sb_q.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      got = {out_hi, out_lo, fault_latched};
      e = sb_q.pop_front();
      checks++;
      if (got != e) begin
        errors++;
        $display("FAIL vec%0d: got %b expected %b", i, got, e);
      end
    end

    // steady PWM period 10 high 3, D=2 then D=0
    for (int pass = 0; pass < 2; pass++) begin
      hi_n = 0; lo_n = 0; z_n = 0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        pwm_in = ((c % 10) < 3);
        dead_cycles = (pass == 0) ? 8'd2 : 8'd0;
        @(posedge clk);
        #1;
        if (c >= 20) begin
          if (out_hi) hi_n++;
          if (out_lo) lo_n++;
          if (!out_hi && !out_lo) z_n++;
        end
      end
      chk(pass == 0 ? "pwm_d2_hi" : "pwm_d0_hi", hi_n,
          pass == 0 ? 4 : 8);
      chk(pass == 0 ? "pwm_d2_lo" : "pwm_d0_lo", lo_n,
          pass == 0 ? 20 : 24);
      chk(pass == 0 ? "pwm_d2_dead" : "pwm_d0_dead", z_n,
          pass == 0 ? 16 : 8);
    end

    // dead_cycles changed mid-interval
    @(negedge clk);
    pwm_in = 1'b0; dead_cycles = 8'd2;
    repeat (10) @(negedge clk);
    pwm_in = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_hi) break;
      if (!out_lo) begin
        n++;
        dead_cycles = 8'd6;
      end
    end
    chk("dt_change_cur", n, 2);
    repeat (5) @(negedge clk);
    pwm_in = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_lo) break;
      if (!out_hi) n++;
    end
    chk("dt_change_next", n, 6);

    // async reset while HIGH, then while in a long DT_L
    @(negedge clk);
    pwm_in = 1'b1; dead_cycles = 8'd1;
    repeat (5) @(negedge clk);
    chk("pre_rst_hi", int'(out_hi), 1);
    @(posedge clk);
    #3;
    n_reset = 1'b0;
    #1;
    chk("async_rst_hi", int'(out_hi), 0);
    chk("async_rst_lo", int'(out_lo), 0);
    @(negedge clk);
    n_reset = 1'b1;
    pwm_in = 1'b0; dead_cycles = 8'd200;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3;
    n_reset = 1'b0;
    #1;
    chk("rst_dtl_hi", int'(out_hi), 0);
    chk("rst_dtl_lo", int'(out_lo), 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    n = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (out_lo) break;
      n++;
    end
    chk("rst_full_dead", n, 200);
    chk("rst_full_hi", int'(out_hi), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
